// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the EX-stage forwarding / hazard controller: select codes,
// FSM states and the shadow scoreboard entry.
package pipe_ctrl_pkg;

  localparam int SB_RAW = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {RUN, LU, MC} state_e;

  typedef struct packed {
    logic              valid;
    logic [SB_RAW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } sb_entry_t;

  function automatic logic fwd_src(input sb_entry_t e);
    return e.valid & e.regwrite & (e.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_sel_unit.sv
// Operand forward-select comparator: picks the youngest in-flight producer of
// src_i, MEM result (current EX entry) ahead of WB result (current MEM entry).
module fwd_sel_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [SB_RAW-1:0] src_i,
  input  logic              use_i,
  input  sb_entry_t         ex_i,
  input  sb_entry_t         mem_i,
  output logic [1:0]        sel_o
);

  logic unused_memread;
  assign unused_memread = ex_i.memread ^ mem_i.memread;

  always_comb begin
    sel_o = FWD_REG;
    if (use_i) begin
      if (fwd_src(ex_i) && (ex_i.rd == src_i)) begin
        sel_o = FWD_MEM;
      end else if (fwd_src(mem_i) && (mem_i.rd == src_i)) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding and hazard controller: shadow scoreboard of EX/MEM/WB,
// registered ALU operand selects, load-use bubble and multi-cycle MUL hold.
module fwd_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int RAW     = SB_RAW
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           id_valid_i,
  input  logic [RAW-1:0] id_rs_i,
  input  logic [RAW-1:0] id_rt_i,
  input  logic           id_use_rs_i,
  input  logic           id_use_rt_i,
  input  logic [RAW-1:0] id_rd_i,
  input  logic           id_regwrite_i,
  input  logic           id_memread_i,
  input  logic           id_multi_i,
  input  logic           flush_i,
  output logic [1:0]     fwd_a_sel_o,
  output logic [1:0]     fwd_b_sel_o,
  output logic           stall_o,
  output logic           bubble_o,
  output logic           ex_hold_o
);

  localparam logic [3:0] CNT_LOAD = 4'(MUL_LAT - 1);

  state_e     state_q, state_d;
  sb_entry_t  ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, id_ent;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d, sel_a, sel_b;
  logic       ex_hold_q, ex_hold_d;
  logic       id_live, lu_hazard, adv;

  // WB is tracked for completeness only; distance-3 hazards go through the regfile.
  logic unused_wb;
  assign unused_wb = ^wb_q;

  assign id_live = id_valid_i & ~flush_i;

  always_comb begin
    id_ent          = '0;
    id_ent.valid    = id_live;
    id_ent.rd       = id_live ? id_rd_i : '0;
    id_ent.regwrite = id_live & id_regwrite_i;
    id_ent.memread  = id_live & id_memread_i;
  end

  assign lu_hazard = (state_q == RUN) & id_live & ex_q.valid & ex_q.memread &
                     ((id_use_rs_i & (id_rs_i == ex_q.rd)) |
                      (id_use_rt_i & (id_rt_i == ex_q.rd)));

  fwd_sel_unit u_sel_a (
    .src_i (id_rs_i),
    .use_i (id_use_rs_i & id_live),
    .ex_i  (ex_q),
    .mem_i (mem_q),
    .sel_o (sel_a)
  );

  fwd_sel_unit u_sel_b (
    .src_i (id_rt_i),
    .use_i (id_use_rt_i & id_live),
    .ex_i  (ex_q),
    .mem_i (mem_q),
    .sel_o (sel_b)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ex_d      = ex_q;
    mem_d     = mem_q;
    wb_d      = wb_q;
    fwd_a_d   = fwd_a_q;
    fwd_b_d   = fwd_b_q;
    ex_hold_d = 1'b0;
    stall_o   = 1'b0;
    bubble_o  = 1'b0;
    adv       = 1'b0;

    case (state_q)
      RUN: begin
        if (lu_hazard) begin
          stall_o  = 1'b1;
          bubble_o = 1'b1;
          wb_d     = mem_q;
          mem_d    = ex_q;
          ex_d     = '0;
          fwd_a_d  = FWD_REG;
          fwd_b_d  = FWD_REG;
          state_d  = LU;
        end else begin
          adv = 1'b1;
        end
      end
      LU: adv = 1'b1;
      MC: begin
        // MUL stays in EX while MEM drains with invalid slots.
        stall_o = 1'b1;
        wb_d    = mem_q;
        mem_d   = '0;
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RUN;
        end else begin
          ex_hold_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    if (adv) begin
      wb_d    = mem_q;
      mem_d   = ex_q;
      ex_d    = id_ent;
      fwd_a_d = sel_a;
      fwd_b_d = sel_b;
      state_d = RUN;
      if (id_live && id_multi_i) begin
        cnt_d     = CNT_LOAD;
        state_d   = MC;
        ex_hold_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      fwd_a_q   <= FWD_REG;
      fwd_b_q   <= FWD_REG;
      ex_hold_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      fwd_a_q   <= fwd_a_d;
      fwd_b_q   <= fwd_b_d;
      ex_hold_q <= ex_hold_d;
    end
  end

  assign fwd_a_sel_o = fwd_a_q;
  assign fwd_b_sel_o = fwd_b_q;
  assign ex_hold_o   = ex_hold_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed pipeline scenarios, then random traffic,
// all compared against an instruction-level pipeline model.
module tb_fwd_hazard_ctrl;

  localparam int MUL_LAT = 4;
  localparam int RAW     = 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           id_valid, id_use_rs, id_use_rt, id_regwrite, id_memread, id_multi, flush;
  logic [RAW-1:0] id_rs, id_rt, id_rd;
  logic [1:0]     fwd_a_sel, fwd_b_sel;
  logic           stall, bubble, ex_hold;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.MUL_LAT(MUL_LAT), .RAW(RAW)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .id_valid_i    (id_valid),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .id_use_rs_i   (id_use_rs),
    .id_use_rt_i   (id_use_rt),
    .id_rd_i       (id_rd),
    .id_regwrite_i (id_regwrite),
    .id_memread_i  (id_memread),
    .id_multi_i    (id_multi),
    .flush_i       (flush),
    .fwd_a_sel_o   (fwd_a_sel),
    .fwd_b_sel_o   (fwd_b_sel),
    .stall_o       (stall),
    .bubble_o      (bubble),
    .ex_hold_o     (ex_hold)
  );

  int total = 0;
  int bad   = 0;
  int stalls = 0;
  int holds  = 0;

  // Model: the instructions now in EX and MEM, the selects they carry, and
  // how many more cycles a MUL keeps the front of the pipe frozen.
  typedef struct packed {
    bit v;
    int rd;
    bit rw;
    bit mr;
  } ment_t;

  ment_t m_ex, m_mem;
  int    m_sa, m_sb, mc_left;
  bit    in_lu, last_stall;

  function automatic int ref_sel(input int src, input bit use_it);
    if (!use_it) return 0;
    if (m_ex.v && m_ex.rw && m_ex.rd != 0 && m_ex.rd == src) return 2;
    if (m_mem.v && m_mem.rw && m_mem.rd != 0 && m_mem.rd == src) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_ex = '0; m_mem = '0; m_sa = 0; m_sb = 0; mc_left = 0; in_lu = 0; last_stall = 0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int v, rs, rt, urs, urt, rd, rw, mr, mul, fl);
    bit live, es, eb;
    int na, nb;
    @(negedge clk);
    id_valid = 1'(v); id_rs = 5'(rs); id_rt = 5'(rt); id_use_rs = 1'(urs); id_use_rt = 1'(urt);
    id_rd = 5'(rd); id_regwrite = 1'(rw); id_memread = 1'(mr); id_multi = 1'(mul); flush = 1'(fl);
    #1;
    live = (v != 0) && (fl == 0);
    es = 0; eb = 0;
    if (mc_left > 0) es = 1;
    else if (!in_lu && live && m_ex.v && m_ex.mr &&
             ((urs != 0 && rs == m_ex.rd) || (urt != 0 && rt == m_ex.rd))) begin
      es = 1; eb = 1;
    end
    chk("stall",   8'(stall),     8'(es));
    chk("bubble",  8'(bubble),    8'(eb));
    chk("ex_hold", 8'(ex_hold),   8'(mc_left > 0));
    chk("fwd_a",   8'(fwd_a_sel), 8'(m_sa));
    chk("fwd_b",   8'(fwd_b_sel), 8'(m_sb));
    if (stall === 1'b1) stalls++;
    if (ex_hold === 1'b1) holds++;
    last_stall = es;
    @(posedge clk);
    if (mc_left > 0) begin
      m_mem = '0;
      mc_left--;
    end else if (eb) begin
      m_mem = m_ex; m_ex = '0; m_sa = 0; m_sb = 0; in_lu = 1;
    end else begin
      na = ref_sel(rs, live && urs != 0);
      nb = ref_sel(rt, live && urt != 0);
      m_mem = m_ex;
      m_ex = '0;
      if (live) begin
        m_ex.v = 1; m_ex.rd = rd; m_ex.rw = (rw != 0); m_ex.mr = (mr != 0);
      end
      m_sa = na; m_sb = nb; in_lu = 0;
      if (live && mul != 0) mc_left = MUL_LAT - 1;
    end
  endtask

  // Present one instruction in ID and hold it there until it advances.
  task automatic issue(input int v, rs, rt, urs, urt, rd, rw, mr, mul, fl);
    int n = 0;
    do begin
      step(v, rs, rt, urs, urt, rd, rw, mr, mul, fl);
      n++;
    end while (last_stall && n < 20);
    chk("issue_bound", 8'(last_stall), 8'(0));
  endtask

  task automatic alu(input int rd, rs, rt);  issue(1, rs, rt, 1, 1, rd, 1, 0, 0, 0); endtask
  task automatic load(input int rd, rs);     issue(1, rs, 0, 1, 0, rd, 1, 1, 0, 0); endtask
  task automatic mul(input int rd, rs, rt);  issue(1, rs, rt, 1, 1, rd, 1, 0, 1, 0); endtask
  task automatic nop();                      issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);    endtask

  task automatic expect_sel(input string tag, input int a, input int b);
    #2;
    chk({tag, "_a"}, 8'(fwd_a_sel), 8'(a));
    chk({tag, "_b"}, 8'(fwd_b_sel), 8'(b));
  endtask

  initial begin
    int s0, h0;
    int v, fl, mr, rw, mu;
    model_reset();
    rst_n = 1'b0;
    id_valid = 0; id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0;
    id_rd = '0; id_regwrite = 0; id_memread = 0; id_multi = 0; flush = 0;
    #1;
    chk("rst_fwd_a",   8'(fwd_a_sel), 8'(0));
    chk("rst_fwd_b",   8'(fwd_b_sel), 8'(0));
    chk("rst_stall",   8'(stall),     8'(0));
    chk("rst_bubble",  8'(bubble),    8'(0));
    chk("rst_ex_hold", 8'(ex_hold),   8'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    s0 = stalls;
    alu(3, 1, 2); alu(5, 3, 4);
    expect_sel("raw_ex", 2, 0);
    alu(3, 1, 2); nop(); alu(6, 4, 3);
    expect_sel("raw_mem", 0, 1);
    alu(3, 1, 2); alu(3, 1, 2); alu(6, 4, 3);
    expect_sel("prio", 0, 2);
    chk("no_stall_alu", 8'(stalls - s0), 8'(0));

    s0 = stalls;
    load(2, 1); alu(7, 2, 1);
    expect_sel("load_use", 1, 0);
    chk("lu_stall_cnt", 8'(stalls - s0), 8'(1));

    alu(0, 1, 2); alu(8, 0, 0);
    expect_sel("r0", 0, 0);

    s0 = stalls; h0 = holds;
    mul(9, 1, 2); alu(10, 9, 4);
    expect_sel("mul_fwd", 2, 0);
    chk("mul_stall_cnt", 8'(stalls - s0), 8'(MUL_LAT - 1));
    chk("mul_hold_cnt",  8'(holds - h0),  8'(MUL_LAT - 1));

    s0 = stalls;
    mul(11, 1, 2); mul(12, 1, 2); nop();
    chk("b2b_stall_cnt", 8'(stalls - s0), 8'(2 * (MUL_LAT - 1)));

    s0 = stalls;
    load(2, 1); issue(1, 2, 1, 1, 1, 7, 1, 0, 0, 1); alu(13, 7, 0);
    expect_sel("flush", 0, 0);
    chk("flush_stall_cnt", 8'(stalls - s0), 8'(0));

    mul(14, 3, 5);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mc_rst_stall",   8'(stall),     8'(0));
    chk("mc_rst_bubble",  8'(bubble),    8'(0));
    chk("mc_rst_ex_hold", 8'(ex_hold),   8'(0));
    chk("mc_rst_fwd_a",   8'(fwd_a_sel), 8'(0));
    chk("mc_rst_fwd_b",   8'(fwd_b_sel), 8'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    s0 = stalls;
    step(1, 1, 2, 1, 1, 4, 1, 0, 0, 0);
    step(1, 4, 2, 1, 1, 5, 1, 0, 0, 0);
    chk("post_rst_run", 8'(stalls - s0), 8'(0));

    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 9) != 0) ? 1 : 0;
      fl = ($urandom_range(0, 7) == 0) ? 1 : 0;
      mr = ($urandom_range(0, 3) == 0) ? 1 : 0;
      rw = (mr != 0 || $urandom_range(0, 1) != 0) ? 1 : 0;
      mu = (v != 0 && fl == 0 && mr == 0 && $urandom_range(0, 9) == 0) ? 1 : 0;
      step(v, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 7), rw, mr, mu, fl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
